// File: rtl/prog_loader.sv
// prog_loader: boot/program sequencer.
// Takes a host byte stream (valid/ready), packs bytes little-endian into 32-bit words,
// writes them to instruction RAM and holds the CPU in reset while a session is running.
// Stream: SYNC_BYTE, LEN lo, LEN hi (word count N), 4*N data bytes [, checksum byte].
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte.
module prog_loader #(
    parameter int unsigned IADDR_W   = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter bit          BOOT_RUN  = 1'b0
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [31:0]        imem_data,
    output logic               imem_wr_en,
    output logic               cpu_nRst,
    output logic               load_busy,
    output logic               load_error
);

    typedef enum logic [2:0] {
        StSync,
        StLen0,
        StLen1,
        StData,
        StCheck,
        StRun,
        StError
    } state_e;

    localparam state_e ResetState = BOOT_RUN ? StRun : StSync;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e DoneState = StCheck;
`else
    localparam state_e DoneState = StRun;
`endif
    // Largest legal word count; widened so 2**IADDR_W itself is representable.
    localparam logic [32:0] Capacity = 33'd1 << IADDR_W;

    state_e r_state;
    state_e w_state_d;

    logic               r_ready_en;
    logic [7:0]         r_len_lo;
    logic [15:0]        r_left;
    logic [IADDR_W-1:0] r_widx;
    logic [1:0]         r_bidx;
    logic [23:0]        r_word;
    logic               r_wr_en;
    logic [IADDR_W-1:0] r_addr;
    logic [31:0]        r_data;
    logic               r_cpu_nrst;
    logic               r_err;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic        w_acc;
    logic        w_is_sync;
    logic        w_sync_hit;
    logic [15:0] w_len;
    logic        w_len_over;
    logic        w_last_word;

    assign w_acc       = rx_valid && rx_ready;
    assign w_is_sync   = (rx_data == SYNC_BYTE);
    // SYNC_BYTE restarts only from idle-like states; inside a session it is plain data.
    assign w_sync_hit  = w_acc && w_is_sync &&
                         ((r_state == StSync) || (r_state == StRun) || (r_state == StError));
    assign w_len       = {rx_data, r_len_lo};
    assign w_len_over  = ({17'd0, w_len} > Capacity);
    assign w_last_word = (r_left == 16'd1);

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ResetState;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StSync: begin
                if (w_sync_hit) w_state_d = StLen0;
            end
            StLen0: begin
                if (w_acc) w_state_d = StLen1;
            end
            StLen1: begin
                if (w_acc) begin
                    if (w_len_over)            w_state_d = StError;
                    else if (w_len == 16'd0)   w_state_d = DoneState;
                    else                       w_state_d = StData;
                end
            end
            StData: begin
                // Leave only once the strobe for the final word is out.
                if (r_wr_en && w_last_word) w_state_d = DoneState;
            end
            StCheck: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (w_acc) w_state_d = (rx_data == r_csum) ? StRun : StError;
`else
                w_state_d = StRun;
`endif
            end
            StRun: begin
                if (w_sync_hit) w_state_d = StLen0;
            end
            StError: begin
                if (w_sync_hit) w_state_d = StLen0;
            end
            default: w_state_d = ResetState;
        endcase
    end

    // Output decode: ready is dropped for the single write-strobe cycle of each word.
    always_comb begin
        rx_ready  = r_ready_en && !r_wr_en;
        load_busy = (r_state == StLen0) || (r_state == StLen1) ||
                    (r_state == StData) || (r_state == StCheck);
    end

    // Length capture, byte packing and RAM write strobe.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_len_lo <= 8'd0;
            r_left   <= 16'd0;
            r_widx   <= '0;
            r_bidx   <= 2'd0;
            r_word   <= 24'd0;
            r_wr_en  <= 1'b0;
            r_addr   <= '0;
            r_data   <= 32'd0;
        end else begin
            r_wr_en <= 1'b0;
            if ((r_state == StLen0) && w_acc) begin
                r_len_lo <= rx_data;
            end
            if ((r_state == StLen1) && w_acc) begin
                r_left <= w_len;
                r_widx <= '0;
                r_bidx <= 2'd0;
            end
            if ((r_state == StData) && w_acc) begin
                r_bidx <= r_bidx + 2'd1;
                unique case (r_bidx)
                    2'd0: r_word[7:0]   <= rx_data;
                    2'd1: r_word[15:8]  <= rx_data;
                    2'd2: r_word[23:16] <= rx_data;
                    2'd3: begin
                        r_wr_en <= 1'b1;
                        r_addr  <= r_widx;
                        r_data  <= {rx_data, r_word};
                    end
                endcase
            end
            if ((r_state == StData) && r_wr_en) begin
                r_widx <= r_widx + 1'b1;
                r_left <= r_left - 16'd1;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR of all data bytes of the current session.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_csum <= 8'd0;
        end else if (w_sync_hit) begin
            r_csum <= 8'd0;
        end else if ((r_state == StData) && w_acc) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    // Handshake enable, registered CPU reset and sticky error flag.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_ready_en <= 1'b0;
            r_cpu_nrst <= BOOT_RUN;
            r_err      <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            // Release one cycle after entering RUN; drop as soon as a new session starts.
            r_cpu_nrst <= (r_state == StRun) && (w_state_d == StRun);
            if ((w_state_d == StError) && (r_state != StError)) begin
                r_err <= 1'b1;
            end else if (w_sync_hit) begin
                r_err <= 1'b0;
            end
        end
    end

    assign imem_addr  = r_addr;
    assign imem_data  = r_data;
    assign imem_wr_en = r_wr_en;
    assign cpu_nRst   = r_cpu_nrst;
    assign load_error = r_err;

endmodule
